// File: rtl/shift_arbiter.sv
// shift_arbiter: round-robin shared right-shifter with a registered, id-tagged output stage.
// Define SHIFT_ARBITER_PRIO0_EN to give requester 0 absolute priority over the rotation.
module shift_right #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 5
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [DEPTH-1:0] b_i,
    input  logic             c_i,
    output logic [WIDTH-1:0] d_o
);
    assign d_o = (a_i >> b_i) | (~({WIDTH{1'b1}} >> b_i) & {WIDTH{c_i}});
endmodule

module shift_arbiter #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 5,
    parameter int NREQ  = 3,
    parameter int IDW   = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  stall_i,
    input  logic [NREQ-1:0]       req_val_i,
    output logic [NREQ-1:0]       req_rdy_o,
    input  logic [NREQ*WIDTH-1:0] req_a_i,
    input  logic [NREQ*DEPTH-1:0] req_b_i,
    input  logic [NREQ-1:0]       req_c_i,
    output logic                  rsp_val_o,
    input  logic                  rsp_rdy_i,
    output logic [WIDTH-1:0]      rsp_d_o,
    output logic [IDW-1:0]        rsp_id_o
);
    logic             rsp_val_q, rsp_val_d;
    logic [WIDTH-1:0] rsp_d_q, rsp_d_d;
    logic [IDW-1:0]   rsp_id_q, rsp_id_d;
    logic [IDW-1:0]   ptr_q, ptr_d;
    logic [IDW-1:0]   ptr_eff, gnt_idx;
    logic [NREQ-1:0]  gnt;
    logic             found, prio_hit, accept;
    logic [WIDTH-1:0] sel_a, sh_d;
    logic [DEPTH-1:0] sel_b;
    logic             sel_c;

    assign accept  = (rsp_rdy_i | !rsp_val_q) & !stall_i;
    assign ptr_eff = (ptr_q < IDW'(NREQ)) ? ptr_q : '0;
`ifdef SHIFT_ARBITER_PRIO0_EN
    assign prio_hit = req_val_i[0];
`else
    assign prio_hit = 1'b0;
`endif

    // Rotating first-valid search starting at the pointer.
    always_comb begin
        int idx;
        gnt     = '0;
        found   = prio_hit;
        gnt[0]  = prio_hit;
        gnt_idx = '0;
        sel_a   = req_a_i[WIDTH-1:0];
        sel_b   = req_b_i[DEPTH-1:0];
        sel_c   = req_c_i[0];
        idx     = 0;
        for (int j = 0; j < NREQ; j++) begin
            idx = (int'(ptr_eff) + j) % NREQ;
            if (!found && req_val_i[idx]) begin
                found        = 1'b1;
                gnt[idx]     = 1'b1;
                gnt_idx      = IDW'(idx);
                sel_a        = req_a_i[idx*WIDTH +: WIDTH];
                sel_b        = req_b_i[idx*DEPTH +: DEPTH];
                sel_c        = req_c_i[idx];
            end
        end
    end

    shift_right #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_shift (
        .a_i(sel_a),
        .b_i(sel_b),
        .c_i(sel_c),
        .d_o(sh_d)
    );

    assign req_rdy_o = gnt & {NREQ{accept & !reset}};
    assign rsp_val_o = rsp_val_q & !stall_i;
    assign rsp_d_o   = rsp_d_q;
    assign rsp_id_o  = rsp_id_q;

    always_comb begin
        rsp_val_d = accept ? |req_val_i : rsp_val_q;
        rsp_d_d   = (accept && found) ? sh_d : rsp_d_q;
        rsp_id_d  = (accept && found) ? gnt_idx : rsp_id_q;
        ptr_d     = (accept && found && !prio_hit)
                  ? ((gnt_idx == IDW'(NREQ-1)) ? '0 : gnt_idx + 1'b1) : ptr_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_val_q <= 1'b0;
            rsp_d_q   <= '0;
            rsp_id_q  <= '0;
            ptr_q     <= '0;
        end else begin
            rsp_val_q <= rsp_val_d;
            rsp_d_q   <= rsp_d_d;
            rsp_id_q  <= rsp_id_d;
            ptr_q     <= ptr_d;
        end
    end
endmodule
